// File: rtl/sample_ram_arbiter_if.sv
// ---------------------------------------------------------------------------
// sample_ram_arbiter_if : config, sample, controller and RAM port-A bundle. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface sample_ram_arbiter_if #(
  parameter int DATA_ADDR_WIDTH = 6,
  parameter int DATA_WIDTH      = 16,
  parameter int FIFO_DEPTH      = 4
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic                       cfg_load;
  logic [DATA_ADDR_WIDTH-1:0] cfg_lptr;
  logic [DATA_ADDR_WIDTH-1:0] cfg_uptr;
  logic                       cfg_err;
  logic                       smp_valid;
  logic [DATA_WIDTH-1:0]      smp_data;
  logic                       smp_ready;
  logic                       ctl_req;
  logic [DATA_ADDR_WIDTH-1:0] ctl_addr;
  logic                       ctl_gnt;
  logic                       en_ram_pa;
  logic                       wr_ram_pa;
  logic [DATA_ADDR_WIDTH-1:0] ram_addr_pa;
  logic [DATA_WIDTH-1:0]      ram_wdata_pa;
  logic [DATA_ADDR_WIDTH-1:0] wr_ptr;
  logic [LVL_W-1:0]           fifo_level;

  modport slave (
    input  cfg_load, cfg_lptr, cfg_uptr, smp_valid, smp_data, ctl_req, ctl_addr,
    output cfg_err, smp_ready, ctl_gnt, en_ram_pa, wr_ram_pa, ram_addr_pa,
           ram_wdata_pa, wr_ptr, fifo_level
  );

  modport master (
    output cfg_load, cfg_lptr, cfg_uptr, smp_valid, smp_data, ctl_req, ctl_addr,
    input  cfg_err, smp_ready, ctl_gnt, en_ram_pa, wr_ram_pa, ram_addr_pa,
           ram_wdata_pa, wr_ptr, fifo_level
  );
endinterface

`default_nettype wire

// File: rtl/sample_ram_arbiter.sv
// ---------------------------------------------------------------------------
// sample_ram_arbiter : shares RAM port A between controller reads and sample FIFO writes. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sample_ram_arbiter #(
  parameter int DATA_ADDR_WIDTH = 6,
  parameter int DATA_WIDTH      = 16,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  sample_ram_arbiter_if.slave  bus
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int IDX_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [DATA_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
  logic [DATA_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [DATA_ADDR_WIDTH-1:0] lptr_q, lptr_d;
  logic [DATA_ADDR_WIDTH-1:0] uptr_q, uptr_d;
  logic [LVL_W-1:0]           level_q, level_d;
  logic [LVL_W-1:0]           defer_q, defer_d;
  logic [IDX_W-1:0]           rd_idx_q, rd_idx_d;
  logic [IDX_W-1:0]           wr_idx_q, wr_idx_d;
  logic                       cfg_err_q, cfg_err_d;
  logic                       init_q;
  logic [DATA_WIDTH-1:0]      mem_q [FIFO_DEPTH];

  logic w_cfg_ok, w_ready, w_push, w_pop, w_flush, w_urgent, w_force;

  assign w_cfg_ok = bus.cfg_load && (bus.cfg_lptr <= bus.cfg_uptr);
  assign w_ready  = init_q && (level_q < LVL_W'(FIFO_DEPTH));
  assign w_push   = bus.smp_valid && w_ready && !w_cfg_ok;
  assign w_urgent = level_q >= LVL_W'(FIFO_DEPTH - 1);
  // Reads blocked by FIFO_DEPTH consecutive writes win the next slot regardless of level.
  assign w_force  = defer_q == LVL_W'(FIFO_DEPTH);

  always_comb begin
    state_d   = ST_IDLE;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wr_ptr_d  = wr_ptr_q;
    lptr_d    = lptr_q;
    uptr_d    = uptr_q;
    defer_d   = '0;
    w_pop     = 1'b0;
    w_flush   = 1'b0;
    cfg_err_d = bus.cfg_load && !w_cfg_ok;

    if (w_cfg_ok) begin
      w_flush  = 1'b1;
      lptr_d   = bus.cfg_lptr;
      uptr_d   = bus.cfg_uptr;
      wr_ptr_d = bus.cfg_lptr;
    end else if (bus.ctl_req && (!w_urgent || w_force)) begin
      state_d = ST_READ;
      addr_d  = bus.ctl_addr;
    end else if (level_q != '0) begin
      state_d  = ST_WRITE;
      addr_d   = wr_ptr_q;
      wdata_d  = mem_q[rd_idx_q];
      w_pop    = 1'b1;
      wr_ptr_d = (wr_ptr_q == uptr_q) ? lptr_q : wr_ptr_q + DATA_ADDR_WIDTH'(1);
      if (bus.ctl_req) begin
        defer_d = defer_q + LVL_W'(1);
      end
    end

    if (w_flush) begin
      level_d  = '0;
      rd_idx_d = '0;
      wr_idx_d = '0;
    end else begin
      level_d  = level_q + LVL_W'(w_push) - LVL_W'(w_pop);
      rd_idx_d = rd_idx_q + IDX_W'(w_pop);
      wr_idx_d = wr_idx_q + IDX_W'(w_push);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_ptr_q  <= '0;
      lptr_q    <= '0;
      uptr_q    <= '0;
      level_q   <= '0;
      defer_q   <= '0;
      rd_idx_q  <= '0;
      wr_idx_q  <= '0;
      cfg_err_q <= 1'b0;
      init_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wr_ptr_q  <= wr_ptr_d;
      lptr_q    <= lptr_d;
      uptr_q    <= uptr_d;
      level_q   <= level_d;
      defer_q   <= defer_d;
      rd_idx_q  <= rd_idx_d;
      wr_idx_q  <= wr_idx_d;
      cfg_err_q <= cfg_err_d;
      init_q    <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_idx_q] <= bus.smp_data;
    end
  end

  assign bus.ctl_gnt      = (state_q == ST_READ);
  assign bus.en_ram_pa    = (state_q != ST_IDLE);
  assign bus.wr_ram_pa    = (state_q == ST_WRITE);
  assign bus.ram_addr_pa  = addr_q;
  assign bus.ram_wdata_pa = wdata_q;
  assign bus.wr_ptr       = wr_ptr_q;
  assign bus.fifo_level   = level_q;
  assign bus.smp_ready    = w_ready;
  assign bus.cfg_err      = cfg_err_q;
endmodule

`default_nettype wire

// File: tb/tb_sample_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sample_ram_arbiter : directed table, corner sequences and random run against a queue model. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sample_ram_arbiter;
  localparam int DAW = 6;
  localparam int DW  = 16;
  localparam int D   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sample_ram_arbiter_if #(.DATA_ADDR_WIDTH(DAW), .DATA_WIDTH(DW), .FIFO_DEPTH(D)) bus ();

  sample_ram_arbiter #(.DATA_ADDR_WIDTH(DAW), .DATA_WIDTH(DW), .FIFO_DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pending samples as a queue, region and pointer as plain values.
  logic [DW-1:0]  q[$];
  logic [DAW-1:0] m_lptr = '0, m_uptr = '0, m_wp = '0, m_addr = '0;
  logic [DW-1:0]  m_wdata = '0;
  bit             m_init = 0, m_gnt = 0, m_en = 0, m_wr = 0, m_err = 0;
  int             m_streak = 0;
  int             gap = 0, max_gap = 0;
  bit             saw_full = 0;

  task automatic model_reset();
    q.delete();
    m_lptr = '0; m_uptr = '0; m_wp = '0; m_addr = '0; m_wdata = '0;
    m_init = 0; m_gnt = 0; m_en = 0; m_wr = 0; m_err = 0; m_streak = 0;
  endtask

  task automatic model_step();
    bit rdy, ok, push;
    int n;
    logic [DW-1:0] din;
    rdy  = m_init && (q.size() < D);
    ok   = bus.cfg_load && (bus.cfg_lptr <= bus.cfg_uptr);
    push = bus.smp_valid && rdy && !ok;
    din  = bus.smp_data;
    m_err = bus.cfg_load && !ok;
    m_gnt = 0; m_en = 0; m_wr = 0;
    n = q.size();
    if (ok) begin
      q.delete();
      m_lptr = bus.cfg_lptr; m_uptr = bus.cfg_uptr; m_wp = bus.cfg_lptr;
      m_streak = 0;
    end else if (bus.ctl_req && (n < D - 1 || m_streak >= D)) begin
      m_gnt = 1; m_en = 1; m_addr = bus.ctl_addr;
      m_streak = 0;
    end else if (n > 0) begin
      m_en = 1; m_wr = 1; m_addr = m_wp;
      m_wdata = q.pop_front();
      m_wp = (m_wp == m_uptr) ? m_lptr : m_wp + 1'b1;
      m_streak = bus.ctl_req ? m_streak + 1 : 0;
    end else begin
      m_streak = 0;
    end
    if (push) q.push_back(din);
    m_init = 1;
  endtask

  task automatic compare_all();
    check("gnt",   bus.ctl_gnt,      m_gnt);
    check("en",    bus.en_ram_pa,    m_en);
    check("wr",    bus.wr_ram_pa,    m_wr);
    check("addr",  bus.ram_addr_pa,  m_addr);
    check("wdata", bus.ram_wdata_pa, m_wdata);
    check("wrptr", bus.wr_ptr,       m_wp);
    check("level", bus.fifo_level,   q.size());
    check("ready", bus.smp_ready,    m_init && (q.size() < D));
    check("err",   bus.cfg_err,      m_err);
  endtask

  task automatic cycle();
    bit rq_e;
    @(posedge clk);
    rq_e = bus.ctl_req;
    model_step();
    #1;
    compare_all();
    if (rq_e && !bus.ctl_gnt) gap++; else gap = 0;
    if (gap > max_gap) max_gap = gap;
    if (bus.fifo_level == D) saw_full = 1;
  endtask

  task automatic drive(input int cl, input int lp, input int up, input int v, input int d,
                       input int rq, input int ra);
    bus.cfg_load  = (cl != 0);
    bus.cfg_lptr  = DAW'(lp);
    bus.cfg_uptr  = DAW'(up);
    bus.smp_valid = (v != 0);
    bus.smp_data  = DW'(d);
    bus.ctl_req   = (rq != 0);
    bus.ctl_addr  = DAW'(ra);
  endtask

  typedef struct {
    int cl, lp, up, v, d, rq, ra;
    int gnt, en, wr, ea, ed, wp, lvl, err;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input int cl, input int lp, input int up, input int v, input int d,
                     input int rq, input int ra, input int gnt, input int en, input int wr,
                     input int ea, input int ed, input int wp, input int lvl, input int err);
    vec_t r;
    r.cl = cl; r.lp = lp; r.up = up; r.v = v; r.d = d; r.rq = rq; r.ra = ra;
    r.gnt = gnt; r.en = en; r.wr = wr; r.ea = ea; r.ed = ed; r.wp = wp; r.lvl = lvl; r.err = err;
    tbl.push_back(r);
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);

    //   cl lp up  v  d     rq ra  gnt en wr ea ed     wp lvl err
    add(0, 0, 0,  0, 0,     0, 0,  0, 0, 0, 0,  0,     0, 0, 0);
    add(1, 8, 11, 0, 0,     0, 0,  0, 0, 0, 0,  0,     8, 0, 0);
    add(0, 0, 0,  1, 'hA0,  0, 0,  0, 0, 0, 0,  0,     8, 1, 0);
    add(0, 0, 0,  1, 'hA1,  0, 0,  0, 1, 1, 8,  'hA0,  9, 1, 0);
    add(0, 0, 0,  1, 'hA2,  0, 0,  0, 1, 1, 9,  'hA1, 10, 1, 0);
    add(0, 0, 0,  1, 'hA3,  0, 0,  0, 1, 1, 10, 'hA2, 11, 1, 0);
    add(0, 0, 0,  1, 'hA4,  0, 0,  0, 1, 1, 11, 'hA3,  8, 1, 0);
    add(0, 0, 0,  1, 'hA5,  0, 0,  0, 1, 1, 8,  'hA4,  9, 1, 0);
    add(0, 0, 0,  0, 0,     0, 0,  0, 1, 1, 9,  'hA5, 10, 0, 0);
    add(0, 0, 0,  0, 0,     0, 0,  0, 0, 0, 0,  0,    10, 0, 0);
    add(0, 0, 0,  1, 'hB0,  0, 0,  0, 0, 0, 0,  0,    10, 1, 0);
    add(0, 0, 0,  0, 0,     1, 20, 1, 1, 0, 20, 0,    10, 1, 0);
    add(0, 0, 0,  0, 0,     1, 20, 1, 1, 0, 20, 0,    10, 1, 0);
    add(0, 0, 0,  0, 0,     1, 20, 1, 1, 0, 20, 0,    10, 1, 0);
    add(0, 0, 0,  0, 0,     0, 0,  0, 1, 1, 10, 'hB0, 11, 0, 0);
    add(0, 0, 0,  0, 0,     0, 0,  0, 0, 0, 0,  0,    11, 0, 0);
    add(0, 0, 0,  1, 'hC0,  0, 0,  0, 0, 0, 0,  0,    11, 1, 0);
    add(1, 12, 5, 1, 'hC1,  1, 3,  1, 1, 0, 3,  0,    11, 2, 1);
    add(0, 0, 0,  0, 0,     0, 0,  0, 1, 1, 11, 'hC0,  8, 1, 0);
    add(0, 0, 0,  0, 0,     0, 0,  0, 1, 1, 8,  'hC1,  9, 0, 0);
    add(0, 0, 0,  1, 'hD0,  0, 0,  0, 0, 0, 0,  0,     9, 1, 0);
    add(0, 0, 0,  1, 'hD1,  1, 7,  1, 1, 0, 7,  0,     9, 2, 0);
    add(0, 0, 0,  1, 'hD2,  1, 7,  1, 1, 0, 7,  0,     9, 3, 0);
    add(1, 16, 19, 1, 'hD3, 1, 7,  0, 0, 0, 0,  0,    16, 0, 0);
    add(0, 0, 0,  0, 0,     1, 7,  1, 1, 0, 7,  0,    16, 0, 0);
    add(0, 0, 0,  0, 0,     0, 0,  0, 0, 0, 0,  0,    16, 0, 0);

    #12;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_ready", bus.smp_ready,    0);
    check("rst_en",    bus.en_ram_pa,    0);
    check("rst_gnt",   bus.ctl_gnt,      0);
    check("rst_wrptr", bus.wr_ptr,       0);
    check("rst_level", bus.fifo_level,   0);
    check("rst_addr",  bus.ram_addr_pa,  0);

    foreach (tbl[i]) begin
      drive(tbl[i].cl, tbl[i].lp, tbl[i].up, tbl[i].v, tbl[i].d, tbl[i].rq, tbl[i].ra);
      cycle();
      check($sformatf("tbl%0d_gnt", i),   bus.ctl_gnt,    tbl[i].gnt);
      check($sformatf("tbl%0d_en", i),    bus.en_ram_pa,  tbl[i].en);
      check($sformatf("tbl%0d_wr", i),    bus.wr_ram_pa,  tbl[i].wr);
      check($sformatf("tbl%0d_wrptr", i), bus.wr_ptr,     tbl[i].wp);
      check($sformatf("tbl%0d_level", i), bus.fifo_level, tbl[i].lvl);
      check($sformatf("tbl%0d_err", i),   bus.cfg_err,    tbl[i].err);
      check($sformatf("tbl%0d_ready", i), bus.smp_ready,  1);
      if (tbl[i].en != 0) check($sformatf("tbl%0d_addr", i), bus.ram_addr_pa, tbl[i].ea);
      if (tbl[i].wr != 0) check($sformatf("tbl%0d_wdata", i), bus.ram_wdata_pa, tbl[i].ed);
    end

    // Saturating stream against a continuously requesting controller.
    gap = 0; max_gap = 0; saw_full = 0;
    for (int k = 0; k < 40; k++) begin
      drive(0, 0, 0, 1, 'h100 + k, 1, 33);
      cycle();
    end
    check("starve_max_gap", max_gap <= D, 1);
    check("starve_saw_full", saw_full, 1);
    for (int k = 0; k < 8; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      cycle();
    end

    // Random traffic.
    for (int k = 0; k < 600; k++) begin
      int lp, up, t, rq, ra;
      lp = $urandom_range(0, 63);
      up = $urandom_range(0, 63);
      if ($urandom_range(0, 3) != 0 && lp > up) begin
        t = lp; lp = up; up = t;
      end
      if (bus.ctl_req && !bus.ctl_gnt) begin
        rq = 1; ra = bus.ctl_addr;
      end else begin
        rq = $urandom_range(0, 1); ra = $urandom_range(0, 63);
      end
      drive($urandom_range(0, 39) == 0, lp, up, $urandom_range(0, 9) < 6,
            $urandom_range(0, 65535), rq, ra);
      cycle();
    end

    // Reset arriving while a write is on port A.
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) cycle();
    drive(0, 0, 0, 1, 'h55, 0, 0);
    cycle();
    cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    check("pre_rst_wr", bus.wr_ram_pa, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_en",  bus.en_ram_pa, 0);
    check("async_rst_wr",  bus.wr_ram_pa, 0);
    check("async_rst_gnt", bus.ctl_gnt,   0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_ready", bus.smp_ready,  0);
    check("rel_level", bus.fifo_level, 0);
    check("rel_wrptr", bus.wr_ptr,     0);
    cycle();
    check("rel_ready_edge", bus.smp_ready, 1);
    drive(0, 0, 0, 1, 'h77, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    cycle();
    check("post_rst_wdata", bus.ram_wdata_pa, 'h77);
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/sample_ram_arbiter.md
Name: sample_ram_arbiter

Overview:
- Shares data-RAM port A between two requesters: the controller's data-vector read fetches and the incoming-sample stream.
- Incoming samples are buffered in a small FIFO and written into a circular sample region [lptr, uptr] of data RAM.
- Controller reads have priority unless the FIFO is near full.
- Exposes the newest-sample address so the controller can compute data_addr for the next MAC pass.

Parameters:
- DATA_ADDR_WIDTH, 6, data-RAM address width (matches controller data_addr).
- DATA_WIDTH, 16, sample word width.
- FIFO_DEPTH, 4, pending-sample FIFO entries (power of two, ≥2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_load  in  1  one-cycle pulse: latch cfg_lptr/cfg_uptr, flush FIFO, set wr_ptr=cfg_lptr.
- cfg_lptr  in  DATA_ADDR_WIDTH  region lower bound (inclusive).
- cfg_uptr  in  DATA_ADDR_WIDTH  region upper bound (inclusive).
- cfg_err  out  1  one-cycle pulse: cfg_load rejected because cfg_lptr > cfg_uptr.
- smp_valid  in  1  sample offered.
- smp_data  in  DATA_WIDTH  sample value.
- smp_ready  out  1  FIFO can accept; transfer on smp_valid && smp_ready at a clock edge.
- ctl_req  in  1  controller read request; held until ctl_gnt.
- ctl_addr  in  DATA_ADDR_WIDTH  read address; stable while ctl_req is high.
- ctl_gnt  out  1  one-cycle grant; RAM access issued in the same cycle.
- en_ram_pa  out  1  port A enable.
- wr_ram_pa  out  1  port A write enable.
- ram_addr_pa  out  DATA_ADDR_WIDTH  port A address.
- ram_wdata_pa  out  DATA_WIDTH  port A write data.
- wr_ptr  out  DATA_ADDR_WIDTH  address the next sample will be written to.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  pending sample count.

Behaviour:
- Reset values: all outputs 0, including smp_ready, wr_ptr, and lptr/uptr (region length 1 at address 0). FIFO is empty.
- smp_ready rises on the first clock edge after rst deasserts.
- Reset mid-operation aborts any access. The RAM enables drop immediately (asynchronous). An in-flight sample is lost.
- smp_ready = (fifo_level < FIFO_DEPTH) after the first post-reset edge. When the FIFO is full there is no push.
- Push and pop in the same cycle leave fifo_level unchanged.
- All port-A outputs and ctl_gnt are registered: a decision at edge n drives them for cycle n..n+1. This gives a request-to-grant latency of 1 cycle minimum.
- FSM states: IDLE, READ, WRITE.
  - Each edge evaluates the next state from ctl_req (excluding a request already granted this cycle) and FIFO status.
  - urgent = fifo_level ≥ FIFO_DEPTH−1.
  - ctl_req && !urgent → READ: ctl_gnt=1, en=1, wr=0, addr=ctl_addr.
  - FIFO non-empty && (urgent || !ctl_req) → WRITE: en=1, wr=1, addr=wr_ptr, wdata=FIFO head; head popped.
  - Otherwise → IDLE: en=0, wr=0, gnt=0. Address and data hold their last value.
  - Back-to-back grants are allowed. A controller holding ctl_req continuously is granted every cycle while not urgent.
- Anti-starvation: a read is never deferred more than FIFO_DEPTH consecutive WRITE cycles. While urgent, each write lowers the level; once the level is below the threshold, READ wins.
- wr_ptr advance on each WRITE: wr_ptr==uptr → lptr, else wr_ptr+1. Comparison is unsigned and exact; there is no modular overflow because lptr ≤ uptr is enforced.
- cfg_load:
  - Has highest priority; the state that edge is forced to IDLE (no grant, no write).
  - Flushes the FIFO (level 0) and sets wr_ptr=cfg_lptr.
  - A pending ctl_req is retained and served from the next edge.
  - A sample offered in the same cycle is dropped, even if smp_ready was high.
  - If cfg_lptr > cfg_uptr: the configuration is unchanged, the FIFO is not flushed, cfg_err pulses for 1 cycle, and arbitration proceeds normally.
- RAM read data returns externally one cycle after the grant and is not handled here.

Test Plan:
- Reset release, cfg_load lptr=8 uptr=11, push 6 samples 0xA0..0xA5 with ctl_req=0 → writes at 8,9,10,11,8,9 with matching data; wr_ptr ends at 10; smp_ready never low.
- ctl_req held with ctl_addr=20, FIFO level 1 → ctl_gnt every cycle, addr 20, wr=0; the sample is written only after ctl_req drops.
- smp_valid held high with ctl_req held high, FIFO_DEPTH=4 → level reaches 3, WRITE forced; read and write interleave; no read waits more than 4 cycles; smp_ready drops only at level 4.
- cfg_load with lptr=12 uptr=5 → cfg_err pulses once; wr_ptr, region and FIFO unchanged; the next write lands at the old wr_ptr.
- cfg_load with FIFO level 3 and ctl_req pending → level 0 and wr_ptr=lptr next cycle, no access that cycle, ctl_gnt the following cycle.
- rst asserted mid-WRITE → en_ram_pa/wr_ram_pa drop immediately; after release level=0, wr_ptr=0, smp_ready high one edge later.
